// File: rtl/fc_param_pkg.sv
// fc_param_pkg: shared types, default sizes and small helpers for the
// fully-connected layer parameter store.
//   state_e     - load/serve FSM states
//   DEF_*       - default layer geometry (256 inputs x 10 neurons)
//   W_WORDS     - packed 32-bit weight words for the default geometry
//   W_AW        - weight word address width for the default geometry
//   B_BYTES     - bias bytes in the load stream for the default geometry
//   clog2_min1  - address width that never collapses to zero bits
//   pack_word   - joins three already-collected bytes with the newest byte
package fc_param_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2,
    READY  = 2'd3
  } state_e;

  localparam int DEF_INPUT_SIZE  = 256;
  localparam int DEF_OUTPUT_SIZE = 10;
  localparam int W_WORDS         = DEF_INPUT_SIZE * DEF_OUTPUT_SIZE / 4;
  localparam int W_AW            = $clog2(W_WORDS);
  localparam int B_BYTES         = 4 * DEF_OUTPUT_SIZE;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Earliest byte sits in the MSB: {b0,b1,b2} collected, b3 arriving now.
  function automatic logic [31:0] pack_word(input logic [23:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/fc_param_ram.sv
// fc_param_ram: simple dual-port synchronous RAM, one write port and one
// registered read port. Storage is not reset; only the read register is.
//   clk, rst_n          - clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata - write port
//   i_re/i_raddr        - read strobe and address; data appears next cycle
//   i_rzero             - when reading, load zero instead of the RAM word
//   o_rdata             - registered read data, held while i_re is low
module fc_param_ram
  import fc_param_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic             i_rzero,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port: storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register: out-of-range/illegal reads are squashed to zero by the
  // caller through i_rzero, so the array is never indexed for them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      if (i_rzero) begin
        r_rdata <= '0;
      end else begin
        r_rdata <= r_mem[i_raddr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fc_param_store.sv
// fc_param_store: weight/bias parameter memory for the FC layer engine.
// Accepts a byte stream (weights in element order, then biases MSB byte
// first), packs four bytes per 32-bit word into on-chip RAM and serves
// weight/bias reads with a fixed one-cycle latency.
//   clk, rst_n                    - clock, async active-low reset
//   ld_start                      - pulse: restart loading at element 0
//   ld_valid/ld_data/ld_ready     - byte stream handshake
//   loaded                        - all parameters stored
//   w_read_en/addr/data           - packed weight read {w[a]..w[a+3]}
//   b_read_en/addr/data           - bias read
//   rd_err                        - sticky illegal-read flag, cleared by ld_start
module fc_param_store
  import fc_param_pkg::*;
#(
  parameter int INPUT_SIZE    = DEF_INPUT_SIZE,
  parameter int OUTPUT_SIZE   = DEF_OUTPUT_SIZE,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int BIAS_WIDTH    = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    ld_start,
  input  logic                                    ld_valid,
  input  logic [7:0]                              ld_data,
  output logic                                    ld_ready,
  output logic                                    loaded,
  input  logic                                    w_read_en,
  input  logic [$clog2(INPUT_SIZE*OUTPUT_SIZE)-1:0] w_read_addr,
  output logic [4*WEIGHTS_WIDTH-1:0]              w_read_data,
  input  logic                                    b_read_en,
  input  logic [$clog2(OUTPUT_SIZE)-1:0]          b_read_addr,
  output logic [BIAS_WIDTH-1:0]                   b_read_data,
  output logic                                    rd_err
);

  localparam int N_W     = INPUT_SIZE * OUTPUT_SIZE;
  localparam int WA_W    = $clog2(N_W);
  localparam int L_WORDS = N_W / 4;
  localparam int L_AW    = WA_W - 2;
  localparam int BA_W    = $clog2(OUTPUT_SIZE);

  localparam logic [L_AW-1:0] W_LAST  = L_AW'(L_WORDS - 1);
  localparam logic [BA_W-1:0] B_LAST  = BA_W'(OUTPUT_SIZE - 1);
  localparam logic [WA_W:0]   W_LIMIT = (WA_W + 1)'(N_W);
  localparam logic [BA_W:0]   B_LIMIT = (BA_W + 1)'(OUTPUT_SIZE);

  state_e          r_state;
  state_e          w_next_state;
  logic [1:0]      r_byte_cnt;
  logic [23:0]     r_shift;
  logic [L_AW-1:0] r_w_word;
  logic [BA_W-1:0] r_b_idx;
  logic            r_ld_ready;
  logic            r_loaded;
  logic            r_rd_err;

  logic            w_accept;
  logic            w_word_done;
  logic            w_w_we;
  logic            w_b_we;
  logic [31:0]     w_word;
  logic            w_w_err;
  logic            w_b_err;

  // ld_start wins over a byte offered in the same cycle: that byte is dropped.
  assign w_accept    = ld_valid & r_ld_ready & ~ld_start;
  assign w_word_done = w_accept & (r_byte_cnt == 2'd3);
  assign w_w_we      = w_word_done & (r_state == LOAD_W);
  assign w_b_we      = w_word_done & (r_state == LOAD_B);
  assign w_word      = pack_word(r_shift, ld_data);

  assign w_w_err = ~r_loaded | (w_read_addr[1:0] != 2'b00) | ({1'b0, w_read_addr} >= W_LIMIT);
  assign w_b_err = ~r_loaded | ({1'b0, b_read_addr} >= B_LIMIT);

  // Next-state logic; ld_start restarts loading from any state.
  always_comb begin
    w_next_state = r_state;
    if (ld_start) begin
      w_next_state = LOAD_W;
    end else begin
      case (r_state)
        IDLE:    w_next_state = IDLE;
        LOAD_W: begin
          if (w_word_done && (r_w_word == W_LAST)) begin
            w_next_state = LOAD_B;
          end else begin
            w_next_state = LOAD_W;
          end
        end
        LOAD_B: begin
          if (w_word_done && (r_b_idx == B_LAST)) begin
            w_next_state = READY;
          end else begin
            w_next_state = LOAD_B;
          end
        end
        READY:   w_next_state = READY;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // State register plus status outputs decoded from the next state so that
  // they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ld_ready <= 1'b0;
      r_loaded   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_ld_ready <= (w_next_state == LOAD_W) || (w_next_state == LOAD_B);
      r_loaded   <= (w_next_state == READY);
    end
  end

  // Byte packing counters; a restart discards any partially collected word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_w_word   <= '0;
      r_b_idx    <= '0;
    end else if (ld_start) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_w_word   <= '0;
      r_b_idx    <= '0;
    end else if (w_accept) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_shift    <= {r_shift[15:0], ld_data};
      if (w_w_we) begin
        r_w_word <= r_w_word + L_AW'(1);
      end
      if (w_b_we) begin
        r_b_idx <= r_b_idx + BA_W'(1);
      end
    end
  end

  // Sticky read-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_err <= 1'b0;
    end else if (ld_start) begin
      r_rd_err <= 1'b0;
    end else if ((w_read_en && w_w_err) || (b_read_en && w_b_err)) begin
      r_rd_err <= 1'b1;
    end
  end

  fc_param_ram #(
    .DEPTH (L_WORDS),
    .WIDTH (4 * WEIGHTS_WIDTH),
    .AW    (L_AW)
  ) u_w_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_w_we),
    .i_waddr (r_w_word),
    .i_wdata (w_word),
    .i_re    (w_read_en),
    .i_rzero (w_w_err),
    .i_raddr (w_read_addr[WA_W-1:2]),
    .o_rdata (w_read_data)
  );

  fc_param_ram #(
    .DEPTH (OUTPUT_SIZE),
    .WIDTH (BIAS_WIDTH),
    .AW    (BA_W)
  ) u_b_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_b_we),
    .i_waddr (r_b_idx),
    .i_wdata (w_word),
    .i_re    (b_read_en),
    .i_rzero (w_b_err),
    .i_raddr (b_read_addr),
    .o_rdata (b_read_data)
  );

  assign ld_ready = r_ld_ready;
  assign loaded   = r_loaded;
  assign rd_err   = r_rd_err;

endmodule

// File: tb/tb_fc_param_store.sv
`timescale 1ns/1ps
module tb_fc_param_store;
  import fc_param_pkg::*;

  localparam int NOUT = DEF_OUTPUT_SIZE;
  localparam int NW   = DEF_INPUT_SIZE * DEF_OUTPUT_SIZE;
  localparam int NTOT = NW + B_BYTES;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'd0;
  logic        ld_ready;
  logic        loaded;
  logic        w_read_en = 1'b0;
  logic [11:0] w_read_addr = 12'd0;
  logic [31:0] w_read_data;
  logic        b_read_en = 1'b0;
  logic [3:0]  b_read_addr = 4'd0;
  logic [31:0] b_read_data;
  logic        rd_err;

  int errors = 0;
  int checks = 0;

  // Reference model: the byte image as streamed plus expected output state.
  logic [7:0]  img [NTOT];
  bit          m_loaded = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_wd = 32'd0;
  logic [31:0] m_bd = 32'd0;

  typedef struct {
    bit          we;
    int          wa;
    bit          be;
    int          ba;
    logic [31:0] ew;
    logic [31:0] eb;
    bit          eerr;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;

  fc_param_store dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .loaded(loaded),
    .w_read_en(w_read_en), .w_read_addr(w_read_addr), .w_read_data(w_read_data),
    .b_read_en(b_read_en), .b_read_addr(b_read_addr), .b_read_data(b_read_data),
    .rd_err(rd_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit w_bad(input int a);
    return !m_loaded || (a % 4) != 0 || a >= NW;
  endfunction

  function automatic bit b_bad(input int i);
    return !m_loaded || i >= NOUT;
  endfunction

  function automatic logic [31:0] exp_w(input int a);
    if (w_bad(a)) return 32'd0;
    return {img[a], img[a+1], img[a+2], img[a+3]};
  endfunction

  function automatic logic [31:0] exp_b(input int i);
    if (b_bad(i)) return 32'd0;
    return {img[NW+4*i], img[NW+4*i+1], img[NW+4*i+2], img[NW+4*i+3]};
  endfunction

  // One read cycle with model-derived expectations.
  task automatic rd(input bit we, input int wa, input bit be, input int ba, input string tag);
    w_read_en = we; w_read_addr = wa[11:0];
    b_read_en = be; b_read_addr = ba[3:0];
    if (we) begin m_wd = exp_w(wa); if (w_bad(wa)) m_err = 1'b1; end
    if (be) begin m_bd = exp_b(ba); if (b_bad(ba)) m_err = 1'b1; end
    tick();
    w_read_en = 1'b0; b_read_en = 1'b0;
    check({tag, "_wdata"}, w_read_data, m_wd);
    check({tag, "_bdata"}, b_read_data, m_bd);
    check({tag, "_rderr"}, {31'd0, rd_err}, {31'd0, m_err});
  endtask

  // Pulse ld_start, then stream n bytes of img (optionally with random stalls).
  task automatic load(input int n, input bit stall);
    int idx = 0;
    int guard = 0;
    bit seen_last = 1'b0;
    ld_start = 1'b1;
    m_loaded = 1'b0;
    m_err = 1'b0;
    tick();
    ld_start = 1'b0;
    check("ldstart_rderr_clear", {31'd0, rd_err}, 32'd0);
    check("ldstart_loaded_low", {31'd0, loaded}, 32'd0);
    while (idx < n && guard < 20000) begin
      ld_data = img[idx];
      ld_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (n == NTOT && idx == NTOT - 1 && !seen_last) begin
        seen_last = 1'b1;
        check("pre_last_loaded", {31'd0, loaded}, 32'd0);
        check("pre_last_ready", {31'd0, ld_ready}, 32'd1);
      end
      if (ld_valid && ld_ready) idx++;
      tick();
      guard++;
    end
    ld_valid = 1'b0;
    if (guard >= 20000) begin
      errors++; checks++;
      $display("FAIL load_timeout: accepted %0d required %0d", idx, n);
    end
    if (n == NTOT) begin
      m_loaded = 1'b1;
      check("done_loaded", {31'd0, loaded}, 32'd1);
      check("done_ready", {31'd0, ld_ready}, 32'd0);
    end
  endtask

  // Back-to-back reads of every aligned weight word, then every bias.
  task automatic sweep(input string tag);
    w_read_en = 1'b1;
    for (int k = 0; k < W_WORDS; k++) begin
      w_read_addr = 12'(4 * k);
      tick();
      check({tag, "_sweep_w"}, w_read_data, exp_w(4 * k));
    end
    w_read_en = 1'b0;
    m_wd = exp_w(4 * (W_WORDS - 1));
    for (int i = 0; i < NOUT; i++) rd(1'b0, 0, 1'b1, i, {tag, "_sweep_b"});
  endtask

  initial begin
    // Image: first 16 weights 0x01..0x10, rest int8 in [-10,10]; biases 5, -10, random.
    for (int i = 0; i < NW; i++) begin
      if (i < 16) img[i] = 8'(i + 1);
      else img[i] = 8'($urandom_range(0, 20) - 10);
    end
    for (int i = NW; i < NTOT; i++) img[i] = 8'($urandom_range(0, 255));
    img[NW+0] = 8'h00; img[NW+1] = 8'h00; img[NW+2] = 8'h00; img[NW+3] = 8'h05;
    img[NW+4] = 8'hFF; img[NW+5] = 8'hFF; img[NW+6] = 8'hFF; img[NW+7] = 8'hF6;

    // Reset state.
    tick(); tick();
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_loaded", {31'd0, loaded}, 32'd0);
    check("rst_wdata", w_read_data, 32'd0);
    check("rst_bdata", b_read_data, 32'd0);
    check("rst_rderr", {31'd0, rd_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Reads before load, misaligned and out-of-range.
    rd(1'b1, 0, 1'b0, 0, "preload_w0");
    rd(1'b1, 2, 1'b0, 0, "preload_w2");
    rd(1'b0, 0, 1'b1, 10, "preload_b10");

    // Partial load of 6 weight bytes, then a full restart.
    load(6, 1'b0);
    check("partial_ready", {31'd0, ld_ready}, 32'd1);
    check("partial_loaded", {31'd0, loaded}, 32'd0);
    load(NTOT, 1'b0);

    // Directed table.
    tbl[0] = '{1'b1, 4,    1'b0, 0,  32'h05060708, 32'h00000000, 1'b0};
    tbl[1] = '{1'b0, 0,    1'b1, 1,  32'h05060708, 32'hFFFFFFF6, 1'b0};
    tbl[2] = '{1'b1, 0,    1'b1, 0,  32'h01020304, 32'h00000005, 1'b0};
    tbl[3] = '{1'b1, 8,    1'b1, 3,  32'h090A0B0C, {img[NW+12], img[NW+13], img[NW+14], img[NW+15]}, 1'b0};
    tbl[4] = '{1'b0, 12,   1'b0, 1,  32'h090A0B0C, {img[NW+12], img[NW+13], img[NW+14], img[NW+15]}, 1'b0};
    tbl[5] = '{1'b1, 12,   1'b0, 0,  32'h0D0E0F10, {img[NW+12], img[NW+13], img[NW+14], img[NW+15]}, 1'b0};
    tbl[6] = '{1'b1, 2,    1'b0, 0,  32'h00000000, {img[NW+12], img[NW+13], img[NW+14], img[NW+15]}, 1'b1};
    tbl[7] = '{1'b0, 0,    1'b1, 10, 32'h00000000, 32'h00000000, 1'b1};
    tbl[8] = '{1'b1, 2560, 1'b0, 0,  32'h00000000, 32'h00000000, 1'b1};
    tbl[9] = '{1'b1, 4,    1'b1, 1,  32'h05060708, 32'hFFFFFFF6, 1'b1};
    for (int v = 0; v < 10; v++) begin
      w_read_en = tbl[v].we; w_read_addr = tbl[v].wa[11:0];
      b_read_en = tbl[v].be; b_read_addr = tbl[v].ba[3:0];
      tick();
      w_read_en = 1'b0; b_read_en = 1'b0;
      check($sformatf("tbl%0d_wdata", v), w_read_data, tbl[v].ew);
      check($sformatf("tbl%0d_bdata", v), b_read_data, tbl[v].eb);
      check($sformatf("tbl%0d_rderr", v), {31'd0, rd_err}, {31'd0, tbl[v].eerr});
    end
    m_wd = tbl[9].ew; m_bd = tbl[9].eb; m_err = tbl[9].eerr;

    sweep("nostall");

    // Random reads: aligned, misaligned and out-of-range addresses.
    for (int r = 0; r < 40; r++) begin
      int wa;
      case ($urandom_range(0, 2))
        0:       wa = 4 * $urandom_range(0, W_WORDS - 1);
        1:       wa = $urandom_range(0, NW - 1);
        default: wa = $urandom_range(0, 4095);
      endcase
      rd(1'($urandom_range(0, 1)), wa, 1'($urandom_range(0, 1)), $urandom_range(0, 15), "rand");
    end

    // Same image with random stalls must give identical contents.
    load(NTOT, 1'b1);
    sweep("stall");

    // Async reset in the middle of the bias phase.
    load(NW + 5, 1'b0);
    check("midb_ready", {31'd0, ld_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midb_rst_ready", {31'd0, ld_ready}, 32'd0);
    check("midb_rst_loaded", {31'd0, loaded}, 32'd0);
    check("midb_rst_wdata", w_read_data, 32'd0);
    m_loaded = 1'b0; m_err = 1'b0; m_wd = 32'd0; m_bd = 32'd0;
    @(negedge clk); rst_n = 1'b1;
    ld_valid = 1'b1;
    tick(); tick(); tick();
    ld_valid = 1'b0;
    check("idle_after_rst_ready", {31'd0, ld_ready}, 32'd0);
    check("idle_after_rst_loaded", {31'd0, loaded}, 32'd0);
    rd(1'b1, 4, 1'b1, 1, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
